// File: rtl/relu_node_backprop_if.sv
// Handshake bundle for the ReLU backprop node: upstream gradient/pre-activation
// in, per-input gradient beats out.
interface relu_node_backprop_if #(
  parameter int WIDTH = 16
) ();
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] grad_in;
  logic signed [WIDTH-1:0] pre_act;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] grad_out;
  logic        [5:0]       grad_idx;
  logic                    grad_last;
  logic signed [WIDTH-1:0] bias_grad;

  modport master (
    output in_valid, grad_in, pre_act, out_ready,
    input  in_ready, out_valid, grad_out, grad_idx, grad_last, bias_grad
  );

  modport slave (
    input  in_valid, grad_in, pre_act, out_ready,
    output in_ready, out_valid, grad_out, grad_idx, grad_last, bias_grad
  );
endinterface

// File: rtl/relu_node_backprop.sv
// Backward pass of the 15-input ReLU node: masks dL/dN by the ReLU derivative
// and serially emits dL/dA_i = W_i * masked_grad, one beat per handshake.
module relu_node_backprop #(
  parameter int                    N_IN    = 15,
  parameter int                    WIDTH   = 16,
  parameter logic [N_IN*WIDTH-1:0] WEIGHTS = {
    16'sd14, 16'sd6, 16'sd8, 16'sd0, -16'sd6, -16'sd19, -16'sd13, 16'sd8,
    -16'sd1, 16'sd14, 16'sd0, -16'sd4, 16'sd8, -16'sd18, 16'sd15
  }
) (
  input  logic                clk,
  input  logic                reset,
  relu_node_backprop_if.slave bus
);

  typedef enum logic [0:0] {IDLE, EMIT} state_t;

  localparam logic [5:0] LAST_IDX = 6'(N_IN - 1);

  state_t                  state_q,     state_d;
  logic                    in_ready_q,  in_ready_d;
  logic                    out_valid_q, out_valid_d;
  logic signed [WIDTH-1:0] grad_out_q,  grad_out_d;
  logic        [5:0]       grad_idx_q,  grad_idx_d;
  logic                    grad_last_q, grad_last_d;
  logic signed [WIDTH-1:0] bias_grad_q, bias_grad_d;
  logic signed [WIDTH-1:0] mask_q,      mask_d;

  logic signed [WIDTH-1:0] mask_in;
  logic        [5:0]       idx_nxt;

  function automatic logic signed [WIDTH-1:0] weight_at(input logic [5:0] idx);
    return WEIGHTS[int'(idx)*WIDTH +: WIDTH];
  endfunction

  // The low WIDTH bits of a two's-complement product do not depend on the
  // upper half, so a WIDTH-wide multiply yields the wrapped full product.
  function automatic logic signed [WIDTH-1:0] mul_wrap(
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] b
  );
    return a * b;
  endfunction

  // Sign bit clear (pre_act >= 0) passes the gradient, matching the forward pass.
  function automatic logic signed [WIDTH-1:0] relu_mask(
    input logic signed [WIDTH-1:0] pre,
    input logic signed [WIDTH-1:0] grad
  );
    return pre[WIDTH-1] ? '0 : grad;
  endfunction

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    grad_out_d  = grad_out_q;
    grad_idx_d  = grad_idx_q;
    grad_last_d = grad_last_q;
    bias_grad_d = bias_grad_q;
    mask_d      = mask_q;
    mask_in     = relu_mask(bus.pre_act, bus.grad_in);
    idx_nxt     = grad_idx_q + 6'd1;

    case (state_q)
      IDLE: begin
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        if (in_ready_q && bus.in_valid) begin
          mask_d      = mask_in;
          bias_grad_d = mask_in;
          grad_idx_d  = '0;
          grad_last_d = 1'b0;
          grad_out_d  = mul_wrap(weight_at(6'd0), mask_in);
          out_valid_d = 1'b1;
          in_ready_d  = 1'b0;
          state_d     = EMIT;
        end
      end
      EMIT: begin
        if (out_valid_q && bus.out_ready) begin
          if (grad_idx_q == LAST_IDX) begin
            out_valid_d = 1'b0;
            grad_last_d = 1'b0;
            in_ready_d  = 1'b1;
            state_d     = IDLE;
          end else begin
            grad_idx_d  = idx_nxt;
            grad_out_d  = mul_wrap(weight_at(idx_nxt), mask_q);
            grad_last_d = (idx_nxt == LAST_IDX);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      grad_out_q  <= '0;
      grad_idx_q  <= '0;
      grad_last_q <= 1'b0;
      bias_grad_q <= '0;
      mask_q      <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      grad_out_q  <= grad_out_d;
      grad_idx_q  <= grad_idx_d;
      grad_last_q <= grad_last_d;
      bias_grad_q <= bias_grad_d;
      mask_q      <= mask_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.grad_out  = grad_out_q;
  assign bus.grad_idx  = grad_idx_q;
  assign bus.grad_last = grad_last_q;
  assign bus.bias_grad = bias_grad_q;

endmodule

// File: doc/relu_node_backprop.md
Name: relu_node_backprop

Overview:
- Backward-pass counterpart of the 15-input fully-connected ReLU node in the layer-4 datapath.
- Accepts one upstream gradient dL/dN per neuron together with that neuron's forward pre-activation sum.
- Applies the ReLU derivative, then serially emits the 15 input gradients dL/dA_i = W_i * masked_grad, one per handshake beat, toward the layer-3 backprop nodes.
- Uses the same weight set and the same 16-bit two's-complement wrap arithmetic as the forward node.

Parameters:
- N_IN, 15, number of node inputs and output beats per transaction (2..64).
- WIDTH, 16, data width of gradients, pre-activation and weights.
- WEIGHTS, {15,-18,8,-4,0,14,-1,8,-13,-19,-6,0,8,6,14}, packed N_IN*WIDTH signed weights; W0 in the least-significant slice.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- in_valid  input  1  grad_in/pre_act valid.
- in_ready  output  1  block can accept a transaction.
- grad_in  input  WIDTH  upstream gradient dL/dN, signed.
- pre_act  input  WIDTH  forward pre-activation sum for this neuron, signed.
- out_valid  output  1  grad_out/grad_idx valid.
- out_ready  input  1  downstream accepts a beat.
- grad_out  output  WIDTH  dL/dA_idx, signed.
- grad_idx  output  6  input index of the current beat, 0..N_IN-1.
- grad_last  output  1  high on the beat with grad_idx == N_IN-1.
- bias_grad  output  WIDTH  masked gradient (dL/dB); stable from acceptance until the next acceptance.

Behaviour:
- Reset (reset=0, asynchronous):
  - in_ready=0, out_valid=0, grad_out=0, grad_idx=0, grad_last=0, bias_grad=0; FSM=IDLE.
  - in_ready rises on the first clk edge after reset deasserts.
- FSM states: IDLE, EMIT.
- IDLE:
  - in_ready=1, out_valid=0.
  - On clk edge with in_valid=1, latch mask_g = (pre_act[WIDTH-1]==0) ? grad_in : 0.
  - ReLU derivative: sign bit 0, including pre_act==0, passes the gradient. This matches the forward node's pass condition.
  - On the same edge: bias_grad<=mask_g, grad_idx<=0, load beat 0 into grad_out, out_valid<=1, in_ready<=0; go to EMIT.
- EMIT:
  - out_valid=1. grad_out = low WIDTH bits of signed(W_idx) * signed(mask_g); no saturation, wraps modulo 2^WIDTH.
  - Beat transfer occurs on a clk edge with out_valid=1 and out_ready=1.
  - Transfer with idx<N_IN-1: idx increments, grad_out updates to the next product, out_valid stays 1.
  - Transfer with idx==N_IN-1 (grad_last=1): out_valid<=0, grad_last<=0, in_ready<=1; go to IDLE.
  - out_ready=0: grad_out, grad_idx and grad_last are held unchanged; out_valid does not drop.
- Latency and throughput:
  - First beat is visible the cycle after acceptance.
  - Full-rate transaction = 1 accept cycle + N_IN beat cycles.
  - in_ready is 0 throughout EMIT; a new in_valid is ignored and must be held by the sender.
  - No accept/emit overlap: back-to-back transactions have one idle cycle between the last beat and the next acceptance.
- Masked case: all N_IN beats are still emitted, each with grad_out=0. Beat count never depends on data.
- Zero weights produce grad_out=0; their beats are not skipped.
- Multiplication: full 2*WIDTH signed product, truncated to the low WIDTH bits.
- Reset asserted mid-EMIT: transaction aborts immediately with no partial completion; outputs go to reset values; no grad_last is emitted.
- grad_out is registered; there is no combinational path from in_* to out_*.

Test Plan:
- Pass-through: grad_in=2, pre_act=0x0010, out_ready=1 → 15 consecutive beats; grad_out = 30, 0xFFDC, 16, 0xFFF8, 0, 28, 0xFFFE, 16, 0xFFE6, 0xFFDA, 0xFFF4, 0, 16, 12, 28; grad_last only at idx 14; bias_grad=2; in_ready=1 on the following cycle.
- Masked: grad_in=0x0005, pre_act=0x8000 → 15 beats, all grad_out=0, bias_grad=0. With pre_act=0x0000, bias_grad=5 and beat 0 = 75.
- Backpressure: grad_in=1, pre_act=1, out_ready toggling 1,0,0,1,… → each beat's value/idx held while out_ready=0; sequence 15, 0xFFEE, 8, … is unchanged and no beat is duplicated or lost.
- Wrap: grad_in=0x1000, pre_act=1 → beat 0 = 0xF000 (15*0x1000), beat 1 = 0xE000 (-18*0x1000 truncated), beat 2 = 0x8000.
- Reset mid-operation: pull reset low at beat 6 → out_valid=0, grad_out=0, in_ready=0 asynchronously. After release, a new transaction with grad_in=1 starts at idx 0 with grad_out=15.
- Busy-ignore: assert in_valid with grad_in=7 during EMIT of a grad_in=1 transaction → current beats are unaffected; grad_in=7 is accepted only after grad_last, and its beat 0 = 105.
